// File: rtl/hovalaag_stream_wrapper.sv
// Streaming host interface for the Hovalaag core: chunked instruction and operand
// loading, IN/OUT FIFOs, and an execute strobe that stalls until operands and space exist.
module hovalaag_stream_wrapper #(
  parameter int IO_W       = 6,
  parameter int DATA_W     = 12,
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         addr,
  input  logic [IO_W-1:0]    io_in,
  output logic [7:0]         io_out,
  output logic               core_clk_en,
  output logic [INSTR_W-1:0] core_instr,
  output logic [DATA_W-1:0]  core_in1,
  output logic [DATA_W-1:0]  core_in2,
  input  logic               core_in1_adv,
  input  logic               core_in2_adv,
  input  logic [DATA_W-1:0]  core_out,
  input  logic [7:0]         core_pc
);

  localparam int CH     = (INSTR_W + IO_W - 1) / IO_W;
  localparam int SR_W   = CH * IO_W;
  localparam int CN     = (DATA_W + IO_W - 1) / IO_W;
  localparam int ST_W   = CN * IO_W;
  localparam int STG_W  = (CN - 1) * IO_W;
  localparam int CCW    = $clog2(CN + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int NW     = CW + 1;
  localparam int NF     = 4;
  localparam int F_IN1  = 0;
  localparam int F_IN2  = 1;
  localparam int F_OUT1 = 2;
  localparam int F_OUT2 = 3;

  typedef enum logic [3:0] {
    CMD_STATUS  = 4'd0,
    CMD_LOAD    = 4'd1,
    CMD_EXEC    = 4'd2,
    CMD_IN1     = 4'd3,
    CMD_IN2     = 4'd4,
    CMD_OUT1_LO = 4'd5,
    CMD_OUT1_HI = 4'd6,
    CMD_OUT2_LO = 4'd7,
    CMD_OUT2_HI = 4'd8,
    CMD_PC      = 4'd9,
    CMD_FLUSH   = 4'd10
  } cmd_e;

  logic [SR_W-1:0]   sr_q, sr_d;
  logic [STG_W-1:0]  stage_q [2], stage_d [2];
  logic [CCW-1:0]    chunk_q [2], chunk_d [2];
  logic [DATA_W-1:0] mem_q [NF][FIFO_DEPTH], mem_d [NF][FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr_q [NF], rd_ptr_d [NF];
  logic [AW-1:0]     wr_ptr_q [NF], wr_ptr_d [NF];
  logic [CW-1:0]     count_q [NF], count_d [NF];
  logic              exec_pending_q, exec_pending_d;
  logic              push_pending_q, push_pending_d;
  logic              push_sel_q, push_sel_d;
  logic              underflow_q, underflow_d;
  logic              overflow_q, overflow_d;

  logic [NF-1:0]     empty, push_en, pop_en;
  logic [1:0]        in_full;
  logic [DATA_W-1:0] head [NF];
  logic              in_ch, out_valid, out_sel, ok, fire, flush;
  logic [ST_W-1:0]   in_word;
  logic [NW-1:0]     out_need;

  always_comb begin
    for (int c = 0; c < NF; c++) begin
      empty[c] = (count_q[c] == '0);
      head[c]  = empty[c] ? '0 : mem_q[c][rd_ptr_q[c]];
    end
    for (int c = 0; c < 2; c++) in_full[c] = (count_q[c] == CW'(FIFO_DEPTH));
  end

  assign core_instr = sr_q[INSTR_W-1:0];
  assign core_in1   = head[F_IN1];
  assign core_in2   = head[F_IN2];
  assign out_valid  = core_instr[14];
  assign out_sel    = core_instr[13];

  // A result still in flight to the selected OUT FIFO already owns one slot.
  assign out_need = {1'b0, (out_sel ? count_q[F_OUT2] : count_q[F_OUT1])}
                  + NW'(push_pending_q && (push_sel_q == out_sel));
  assign ok = (!core_in1_adv || !empty[F_IN1]) &&
              (!core_in2_adv || !empty[F_IN2]) &&
              (!out_valid || (out_need < NW'(FIFO_DEPTH)));
  assign fire        = exec_pending_q && ok;
  assign core_clk_en = fire;

  assign in_ch   = (addr == CMD_IN2);
  assign in_word = {io_in, stage_q[in_ch]};

  // NOTE: every always_comb output gets a default before any branch, so no latches are inferred.
  always_comb begin
    sr_d        = sr_q;
    stage_d     = stage_q;
    chunk_d     = chunk_q;
    underflow_d = underflow_q;
    overflow_d  = overflow_q;
    push_en     = '0;
    pop_en      = '0;
    flush       = 1'b0;
    // An execute arriving on the firing cycle queues the next one; otherwise it is redundant.
    exec_pending_d = (addr == CMD_EXEC) || (exec_pending_q && !fire);
    push_pending_d = fire && out_valid;
    push_sel_d     = fire ? out_sel : push_sel_q;

    case (addr)
      CMD_LOAD: if (!exec_pending_q) sr_d = {io_in, sr_q[SR_W-1:IO_W]};
      CMD_IN1, CMD_IN2: begin
        stage_d[in_ch] = in_word[ST_W-1:IO_W];
        if (chunk_q[in_ch] == CCW'(CN - 1)) begin
          chunk_d[in_ch] = '0;
          if (in_full[in_ch]) overflow_d = 1'b1;
          else                push_en[{1'b0, in_ch}] = 1'b1;
        end else begin
          chunk_d[in_ch] = chunk_q[in_ch] + CCW'(1);
        end
      end
      CMD_OUT1_HI: begin
        if (empty[F_OUT1]) underflow_d = 1'b1;
        else               pop_en[F_OUT1] = 1'b1;
      end
      CMD_OUT2_HI: begin
        if (empty[F_OUT2]) underflow_d = 1'b1;
        else               pop_en[F_OUT2] = 1'b1;
      end
      CMD_FLUSH: begin
        flush       = 1'b1;
        chunk_d     = '{default: '0};
        underflow_d = 1'b0;
        overflow_d  = 1'b0;
      end
      default: ;
    endcase

    if (fire) begin
      pop_en[F_IN1] = core_in1_adv;
      pop_en[F_IN2] = core_in2_adv;
    end
    if (push_pending_q) push_en[{1'b1, push_sel_q}] = 1'b1;
  end

  // Flush empties the FIFOs but a result already in flight still lands afterwards.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int c = 0; c < NF; c++) begin
      if (flush) begin
        rd_ptr_d[c] = '0;
        wr_ptr_d[c] = '0;
        count_d[c]  = '0;
      end else if (pop_en[c]) begin
        rd_ptr_d[c] = rd_ptr_q[c] + AW'(1);
        count_d[c]  = count_q[c] - CW'(1);
      end
      if (push_en[c]) begin
        mem_d[c][wr_ptr_d[c]] = (c < 2) ? in_word[DATA_W-1:0] : core_out;
        wr_ptr_d[c] = wr_ptr_d[c] + AW'(1);
        count_d[c]  = count_d[c] + CW'(1);
      end
    end
  end

  always_comb begin
    io_out = '0;
    case (addr)
      CMD_STATUS:  io_out = {underflow_q, overflow_q, !empty[F_OUT2], !empty[F_OUT1],
                             in_full[1], in_full[0], push_pending_q, exec_pending_q};
      CMD_OUT1_LO: io_out = head[F_OUT1][7:0];
      CMD_OUT1_HI: io_out = 8'(head[F_OUT1] >> 8);
      CMD_OUT2_LO: io_out = head[F_OUT2][7:0];
      CMD_OUT2_HI: io_out = 8'(head[F_OUT2] >> 8);
      CMD_PC:      io_out = core_pc;
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q           <= '0;
      stage_q        <= '{default: '0};
      chunk_q        <= '{default: '0};
      rd_ptr_q       <= '{default: '0};
      wr_ptr_q       <= '{default: '0};
      count_q        <= '{default: '0};
      exec_pending_q <= 1'b0;
      push_pending_q <= 1'b0;
      push_sel_q     <= 1'b0;
      underflow_q    <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      sr_q           <= sr_d;
      stage_q        <= stage_d;
      chunk_q        <= chunk_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      exec_pending_q <= exec_pending_d;
      push_pending_q <= push_pending_d;
      push_sel_q     <= push_sel_d;
      underflow_q    <= underflow_d;
      overflow_q     <= overflow_d;
    end
  end

  // NOTE: FIFO storage is not reset; a zero count masks stale entries and heads read 0 when empty.
  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: tb/tb_hovalaag_stream_wrapper.sv
// Bench for hovalaag_stream_wrapper: directed scenarios then random commands, checked
// by a queue-based reference model feeding a scoreboard drained by a separate monitor.
module tb_hovalaag_stream_wrapper;

  localparam int IO_W       = 6;
  localparam int DATA_W     = 12;
  localparam int INSTR_W    = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int CH         = (INSTR_W + IO_W - 1) / IO_W;
  localparam int CN         = (DATA_W + IO_W - 1) / IO_W;

  logic               clk = 1'b0;
  logic               reset;
  logic [3:0]         addr;
  logic [IO_W-1:0]    io_in;
  logic [7:0]         io_out;
  logic               core_clk_en;
  logic [INSTR_W-1:0] core_instr;
  logic [DATA_W-1:0]  core_in1, core_in2, core_out;
  logic               core_in1_adv, core_in2_adv;
  logic [7:0]         core_pc;

  always #5 clk = ~clk;

  hovalaag_stream_wrapper #(
    .IO_W(IO_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .io_in(io_in), .io_out(io_out),
    .core_clk_en(core_clk_en), .core_instr(core_instr),
    .core_in1(core_in1), .core_in2(core_in2),
    .core_in1_adv(core_in1_adv), .core_in2_adv(core_in2_adv),
    .core_out(core_out), .core_pc(core_pc)
  );

  typedef struct {
    int                 cyc;
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  in1;
    logic [DATA_W-1:0]  in2;
  } fire_t;

  typedef struct {
    int         cyc;
    logic [3:0] a;
    logic [7:0] val;
  } rd_t;

  fire_t fire_q[$];
  rd_t   rd_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  bit    mon_on   = 1'b0;

  // Reference model state
  logic [DATA_W-1:0] m_fifo [4][$];
  longint unsigned   m_sr;
  int unsigned       m_word [2];
  int                m_chunk [2];
  bit                m_exec, m_pp, m_psel, m_under, m_over;

  // Stimulus knobs applied at the next drive point
  bit                a1, a2, cout_rand;
  logic [DATA_W-1:0] cout_val;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_fifo[i].delete();
    m_sr = 0;
    for (int i = 0; i < 2; i++) begin
      m_word[i]  = 0;
      m_chunk[i] = 0;
    end
    m_exec = 0; m_pp = 0; m_psel = 0; m_under = 0; m_over = 0;
  endfunction

  // One clock cycle: drive a command, predict this cycle's outputs, then advance the model.
  task automatic step(input logic [3:0] a, input logic [IO_W-1:0] d = '0, input bit rst = 1'b0);
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  h [4];
    logic [7:0]         exp_io;
    bit                 ov, sel, ok, fire;
    bit                 full_in [2];
    int                 ch, o, pend;
    fire_t              fe;
    rd_t                re;
    @(posedge clk); #1;
    reset        = rst;
    addr         = a;
    io_in        = d;
    core_in1_adv = a1;
    core_in2_adv = a2;
    core_out     = cout_rand ? DATA_W'($urandom) : cout_val;
    core_pc      = 8'($urandom);

    instr = m_sr[INSTR_W-1:0];
    for (int i = 0; i < 4; i++) h[i] = (m_fifo[i].size() > 0) ? m_fifo[i][0] : '0;
    ov   = instr[14];
    sel  = instr[13];
    pend = (m_pp && m_psel == sel) ? 1 : 0;
    ok   = (!a1 || m_fifo[0].size() > 0) && (!a2 || m_fifo[1].size() > 0) &&
           (!ov || (m_fifo[2 + int'(sel)].size() + pend) < FIFO_DEPTH);
    fire = m_exec && ok;
    if (fire) begin
      fe.cyc = cyc; fe.instr = instr; fe.in1 = h[0]; fe.in2 = h[1];
      fire_q.push_back(fe);
    end

    case (a)
      4'd0: begin
        exp_io[7] = m_under;
        exp_io[6] = m_over;
        exp_io[5] = m_fifo[3].size() > 0;
        exp_io[4] = m_fifo[2].size() > 0;
        exp_io[3] = m_fifo[1].size() == FIFO_DEPTH;
        exp_io[2] = m_fifo[0].size() == FIFO_DEPTH;
        exp_io[1] = m_pp;
        exp_io[0] = m_exec;
      end
      4'd5:    exp_io = 8'(h[2] % 256);
      4'd6:    exp_io = 8'(h[2] / 256);
      4'd7:    exp_io = 8'(h[3] % 256);
      4'd8:    exp_io = 8'(h[3] / 256);
      4'd9:    exp_io = core_pc;
      default: exp_io = 8'h00;
    endcase
    if (a == 4'd0 || (a >= 4'd5 && a <= 4'd9) || a >= 4'd11) begin
      re.cyc = cyc; re.a = a; re.val = exp_io;
      rd_q.push_back(re);
    end

    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) full_in[i] = (m_fifo[i].size() == FIFO_DEPTH);
    if (a == 4'd10) begin
      for (int i = 0; i < 4; i++) m_fifo[i].delete();
      for (int i = 0; i < 2; i++) begin
        m_word[i]  = 0;
        m_chunk[i] = 0;
      end
      m_under = 0; m_over = 0;
    end else begin
      if (fire && a1) void'(m_fifo[0].pop_front());
      if (fire && a2) void'(m_fifo[1].pop_front());
      case (a)
        4'd1: if (!m_exec) m_sr = (m_sr >> IO_W) | (longint'(d) << (IO_W * (CH - 1)));
        4'd3, 4'd4: begin
          ch = int'(a) - 3;
          m_word[ch] = m_word[ch] | (int'(d) << (IO_W * m_chunk[ch]));
          m_chunk[ch]++;
          if (m_chunk[ch] == CN) begin
            if (full_in[ch]) m_over = 1;
            else             m_fifo[ch].push_back(DATA_W'(m_word[ch]));
            m_word[ch]  = 0;
            m_chunk[ch] = 0;
          end
        end
        4'd6, 4'd8: begin
          o = (a == 4'd6) ? 2 : 3;
          if (m_fifo[o].size() == 0) m_under = 1;
          else                       void'(m_fifo[o].pop_front());
        end
        default: ;
      endcase
    end
    if (m_pp) m_fifo[2 + int'(m_psel)].push_back(core_out);
    m_pp = fire && ov;
    if (fire) m_psel = sel;
    m_exec = (a == 4'd2) || (m_exec && !fire);
  endtask

  task automatic load_instr(input logic [31:0] v);
    logic [63:0] t;
    for (int k = 0; k < CH; k++) begin
      t = 64'(v) >> (IO_W * k);
      step(4'd1, t[IO_W-1:0]);
    end
  endtask

  task automatic push_word(input int ch, input logic [DATA_W-1:0] w);
    logic [63:0] t;
    for (int k = 0; k < CN; k++) begin
      t = 64'(w) >> (IO_W * k);
      step(4'(3 + ch), t[IO_W-1:0]);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (mon_on) begin
      bit exp_fire;
      fire_t fe;
      rd_t re;
      exp_fire = (fire_q.size() > 0) && (fire_q[0].cyc == cyc);
      if (core_clk_en !== 1'b0 || exp_fire) begin
        check("core_clk_en", core_clk_en, exp_fire);
        if (exp_fire) begin
          fe = fire_q.pop_front();
          check("core_instr", core_instr, fe.instr);
          check("core_in1", core_in1, fe.in1);
          check("core_in2", core_in2, fe.in2);
        end
      end
      while (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        re = rd_q.pop_front();
        check($sformatf("io_out addr=%0d", re.a), io_out, re.val);
      end
    end
  end

  initial begin
    int r;
    reset = 1'b1; addr = '0; io_in = '0; core_out = '0; core_pc = '0;
    core_in1_adv = 1'b0; core_in2_adv = 1'b0;
    a1 = 0; a2 = 0; cout_rand = 1; cout_val = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    mon_on = 1'b1;

    // Reset state
    step(4'd0); step(4'd5); step(4'd8); step(4'd12);

    // Single execute with a result into OUT1
    load_instr(32'h0000_4000);
    cout_rand = 0; cout_val = 12'hABC;
    step(4'd2); step(4'd11); step(4'd11);
    cout_rand = 1;
    step(4'd5); step(4'd6); step(4'd0);

    // Operand stall on empty IN1, released by a push
    load_instr(32'h0000_0001);
    a1 = 1;
    step(4'd2);
    repeat (20) step(4'd0);
    step(4'd3, 6'h05); step(4'd3, 6'h01);
    step(4'd0); step(4'd0);
    a1 = 0;

    // OUT2 full stall released by a pop; load during stall is ignored
    load_instr(32'h0000_6000);
    repeat (4) begin
      step(4'd2); step(4'd11); step(4'd11);
    end
    step(4'd2);
    step(4'd1, 6'h3F);
    repeat (3) step(4'd0);
    step(4'd7); step(4'd8);
    repeat (3) step(4'd0);
    repeat (5) step(4'd8);
    step(4'd0); step(4'd10); step(4'd0);

    // IN1 overflow then flush
    for (int w = 0; w < 5; w++) push_word(0, DATA_W'(12'h100 + w * 12'h111));
    step(4'd0); step(4'd10); step(4'd0);

    // Back-to-back executes with OUT1 at three entries
    load_instr(32'h0000_4000);
    repeat (3) begin
      step(4'd2); step(4'd11); step(4'd11);
    end
    step(4'd2); step(4'd2);
    repeat (3) step(4'd0);
    step(4'd6);
    repeat (3) step(4'd0);
    repeat (5) step(4'd6);

    // Reset while a result is in flight
    step(4'd2); step(4'd0);
    step(4'd0, '0, 1'b1);
    step(4'd0); step(4'd5); step(4'd0);

    // Random command stream
    for (int n = 0; n < 3000; n++) begin
      if (!m_exec) begin
        a1 = ($urandom_range(0, 3) == 0);
        a2 = ($urandom_range(0, 3) == 0);
      end
      r = $urandom_range(0, 99);
      if      (r < 8)  step(4'd1, IO_W'($urandom));
      else if (r < 18) step(4'd2);
      else if (r < 36) step(4'd3, IO_W'($urandom));
      else if (r < 52) step(4'd4, IO_W'($urandom));
      else if (r < 58) step(4'd5);
      else if (r < 68) step(4'd6);
      else if (r < 73) step(4'd7);
      else if (r < 83) step(4'd8);
      else if (r < 90) step(4'd0);
      else if (r < 92) step(4'd10);
      else if (r < 95) step(4'd9);
      else             step(4'(11 + $urandom_range(0, 4)));
    end

    repeat (4) step(4'd11);
    @(negedge clk); #1;
    check("fire_q drained", fire_q.size(), 0);
    check("rd_q drained", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
